// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - fetch stage with decoupled prefetch queue, imem loader port and HALT detection
// Optional: define IF_PC_RANGE_TRAP_EN to halt fetch when the PC runs past the end of imem.
module if_prefetch_stage #(
   parameter int            NB        = 32,
   parameter int            TAM_I     = 256,
   parameter int            DEPTH     = 4,
   parameter logic [NB-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_step,
   input  logic                         i_id_ready,
   input  logic                         i_branch,
   input  logic [NB-1:0]                i_branch_addr,
   input  logic                         i_imem_we,
   input  logic [$clog2(TAM_I)-1:0]     i_imem_addr,
   input  logic [NB-1:0]                i_imem_data,
   output logic                         o_valid,
   output logic [NB-1:0]                o_pc,
   output logic [NB-1:0]                o_pc4,
   output logic [NB-1:0]                o_pc8,
   output logic [NB-1:0]                o_instruction,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_halt
);

   localparam int AW = $clog2(TAM_I);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [NB-1:0] mem     [TAM_I];
   logic [NB-1:0] q_pc    [DEPTH];
   logic [NB-1:0] q_instr [DEPTH];

   logic [NB-1:0] fetch_pc;
   logic [NB-1:0] fetch_word;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          halt;
   logic          valid;
   logic          full;
   logic          pop;
   logic          can_fetch;
   logic          push;
   logic          pc_out_of_range;

   assign fetch_word = mem[fetch_pc[AW+1:2]];
   assign valid      = (count != '0);
   assign full       = (count == CW'(DEPTH));
   assign pop        = i_step & valid & i_id_ready & ~i_branch;
   // a full queue can still accept a word when the head leaves in the same cycle
   assign can_fetch  = i_step & ~i_branch & ~halt & (~full | pop);

`ifdef IF_PC_RANGE_TRAP_EN
   localparam logic [NB:0] PC_LIMIT = (NB+1)'(4 * TAM_I);
   assign pc_out_of_range = ({1'b0, fetch_pc} >= PC_LIMIT);
`else
   assign pc_out_of_range = 1'b0;
`endif

   assign push = can_fetch & ~pc_out_of_range;

   // storage arrays carry no reset; validity is tracked by the pointers and count
   always_ff @(posedge i_clk) begin
      if (i_imem_we) begin
         mem[i_imem_addr] <= i_imem_data;
      end
      if (push) begin
         q_pc[wr_ptr]    <= fetch_pc;
         q_instr[wr_ptr] <= fetch_word;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fetch_pc <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         halt     <= 1'b0;
      end else if (i_step) begin
         if (i_branch) begin
            fetch_pc <= i_branch_addr & ~NB'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halt     <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + PW'(1);
               fetch_pc <= fetch_pc + NB'(4);
               if (fetch_word == HALT_WORD) begin
                  halt <= 1'b1;
               end
            end else if (can_fetch && pc_out_of_range) begin
               halt <= 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
               count <= count + CW'(1);
            end else if (pop && !push) begin
               count <= count - CW'(1);
            end
         end
      end
   end

   always_comb begin
      o_valid       = valid;
      o_count       = count;
      o_halt        = halt;
      o_pc          = '0;
      o_pc4         = '0;
      o_pc8         = '0;
      o_instruction = '0;
      if (valid) begin
         o_pc          = q_pc[rd_ptr];
         o_pc4         = q_pc[rd_ptr] + NB'(4);
         o_pc8         = q_pc[rd_ptr] + NB'(8);
         o_instruction = q_instr[rd_ptr];
      end
   end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - directed self-checking bench for if_prefetch_stage
module tb_if_prefetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        step;
   logic        ready;
   logic        branch;
   logic [31:0] baddr;
   logic        we;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] pc8;
   logic [31:0] instr;
   logic [2:0]  count;
   logic        halt;

   int errors = 0;
   int checks = 0;

   if_prefetch_stage dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_step        (step),
      .i_id_ready    (ready),
      .i_branch      (branch),
      .i_branch_addr (baddr),
      .i_imem_we     (we),
      .i_imem_addr   (waddr),
      .i_imem_data   (wdata),
      .o_valid       (valid),
      .o_pc          (pc),
      .o_pc4         (pc4),
      .o_pc8         (pc8),
      .o_instruction (instr),
      .o_count       (count),
      .o_halt        (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input int i);
      if (i < 4) return 32'(32'h11 * (i + 1));
      return 32'(32'hA000 + i);
   endfunction

   task automatic load(input int a, input logic [31:0] d);
      we    = 1'b1;
      waddr = 8'(a);
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; step = 1'b0; ready = 1'b0; branch = 1'b0; baddr = '0;
      we = 1'b0; waddr = '0; wdata = '0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) load(i, word(i));

      check("rst_valid", 32'(valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_halt",  32'(halt),  0);
      check("rst_pc",    pc,    0);
      check("rst_instr", instr, 0);

      // fill with ID stalled
      rst = 1'b0; step = 1'b1; ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("fill_count", 32'(count), (k < 4) ? k : 4);
         check("fill_valid", 32'(valid), 1);
         check("fill_pc",    pc,    0);
         check("fill_instr", instr, 32'h11);
      end

      // full queue streaming: push and pop each cycle
      ready = 1'b1;
      check("full_pc4", pc4, 4);
      check("full_pc8", pc8, 8);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         check("stream_pc",    pc,    32'(4 * j));
         check("stream_instr", instr, word(j));
         check("stream_pc8",   pc8,   32'(4 * j + 8));
         check("stream_count", 32'(count), 4);
      end

      // branch redirect to 0x42 -> word-aligned 0x40
      branch = 1'b1; baddr = 32'h42; ready = 1'b0;
      @(negedge clk);
      branch = 1'b0;
      check("br_valid", 32'(valid), 0);
      check("br_count", 32'(count), 0);
      check("br_pc",    pc, 0);
      @(negedge clk);
      check("br_valid2", 32'(valid), 1);
      check("br_pc2",    pc,    32'h40);
      check("br_instr2", instr, word(16));
      check("br_count2", 32'(count), 1);
      @(negedge clk);
      @(negedge clk);
      check("br_count3", 32'(count), 3);
      branch = 1'b1; baddr = 32'h0B;
      @(negedge clk);
      branch = 1'b0;
      check("br3_valid", 32'(valid), 0);
      @(negedge clk);
      check("br3_pc",    pc,    32'h08);
      check("br3_instr", instr, 32'h33);

      // HALT at imem[5]
      step = 1'b0;
      load(5, 32'hFFFF_FFFF);
      step = 1'b1; branch = 1'b1; baddr = 32'h0; ready = 1'b1;
      @(negedge clk);
      branch = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("halt_pc", pc, 32'(4 * (k - 1)));
         check("halt_flag", 32'(halt), (k == 6) ? 1 : 0);
      end
      check("halt_instr", instr, 32'hFFFF_FFFF);
      @(negedge clk);
      check("halt_drain_valid", 32'(valid), 0);
      check("halt_drain_count", 32'(count), 0);
      check("halt_sticky",      32'(halt),  1);
      @(negedge clk);
      @(negedge clk);
      check("halt_fetch_pc", dut.fetch_pc, 32'h18);
      check("halt_no_push",  32'(valid), 0);

      // step freeze mid-stream
      step = 1'b0;
      load(5, word(5));
      step = 1'b1; branch = 1'b1; baddr = 32'h0; ready = 1'b1;
      @(negedge clk);
      branch = 1'b0;
      check("unhalt", 32'(halt), 0);
      repeat (3) @(negedge clk);
      check("pre_freeze_pc", pc, 32'h08);
      step = 1'b0; branch = 1'b1; baddr = 32'h80;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("freeze_pc",    pc, 32'h08);
         check("freeze_count", 32'(count), 1);
         check("freeze_valid", 32'(valid), 1);
      end
      branch = 1'b0; step = 1'b1;
      @(negedge clk);
      check("resume_pc",    pc,    32'h0C);
      check("resume_instr", instr, 32'h44);
      @(negedge clk);
      check("resume_pc2",    pc,    32'h10);
      check("resume_instr2", instr, word(4));

      // asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      check("async_valid", 32'(valid), 0);
      check("async_count", 32'(count), 0);
      check("async_pc",    pc, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("restart_valid", 32'(valid), 1);
      check("restart_pc",    pc,    0);
      check("restart_instr", instr, 32'h11);
      @(negedge clk);
      check("restart_pc2", pc, 32'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
